// File: rtl/ob_cmd_arb.sv
// Round-robin arbiter sharing the order-book command port among N requesters,
// with credit-based flow control, a per-requester burst limit and a quiesce/drain handshake.
package ob_pkg;
  typedef struct packed {
    logic [3:0]  op;
    logic [11:0] id;
    logic [15:0] qty;
  } cmd_t;
endpackage

module ob_cmd_arb #(
  parameter int N       = 4,
  parameter int W       = $bits(ob_pkg::cmd_t),
  parameter int CREDITS = 4,
  parameter int BURST   = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req_vld,
  input  logic [N*W-1:0] req_cmd,
  input  logic [N-1:0]   req_en,
  output logic [N-1:0]   req_accept,
  output logic           cmd_vld_r,
  output logic [W-1:0]   cmd_r,
  input  logic           cmd_full_r,
  input  logic           cmd_credit,
  input  logic           quiesce_req,
  output logic           quiesce_ack_r,
  output logic           credit_err_r
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(CREDITS + 1);
  localparam int BW = $clog2(BURST + 1);

  typedef enum logic [1:0] {RUN, DRAIN, IDLE} state_t;

  state_t         state, state_nxt;
  logic [PW-1:0]  rr_ptr, rr_ptr_nxt, last_g, gnt_idx, idx;
  logic [BW-1:0]  burst_cnt, burst_nxt;
  logic [CW-1:0]  credit_cnt, credit_nxt;
  logic [N-1:0]   elig, sel_oh;
  logic           found, grant, others, credit_ovf;

  assign elig = req_vld & req_en;

  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    idx     = '0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = PW'((32'(rr_ptr) + i) % N);
      if (!found && elig[idx]) begin
        found   = 1'b1;
        gnt_idx = idx;
      end
    end
  end

  // rst gates the combinational accept so it reads zero while reset is held
  assign grant      = rst && (state == RUN) && (credit_cnt != '0) && !cmd_full_r && found;
  assign sel_oh     = N'(1) << gnt_idx;
  assign others     = |(elig & ~sel_oh);
  assign req_accept = grant ? sel_oh : '0;

  always_comb begin
    burst_nxt  = burst_cnt;
    rr_ptr_nxt = rr_ptr;
    if (grant) begin
      if (burst_cnt != '0 && gnt_idx == last_g)
        burst_nxt = (burst_cnt == BW'(BURST)) ? burst_cnt : burst_cnt + 1'b1;
      else
        burst_nxt = BW'(1);
      if (burst_nxt < BW'(BURST) && others)
        rr_ptr_nxt = gnt_idx;
      else
        rr_ptr_nxt = (gnt_idx == PW'(N - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_comb begin
    credit_nxt = credit_cnt;
    credit_ovf = 1'b0;
    if (grant && !cmd_credit)
      credit_nxt = credit_cnt - 1'b1;
    else if (!grant && cmd_credit) begin
      if (credit_cnt == CW'(CREDITS))
        credit_ovf = 1'b1;
      else
        credit_nxt = credit_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (quiesce_req) state_nxt = DRAIN;
      DRAIN: begin
        if (!quiesce_req)
          state_nxt = RUN;
        else if (credit_cnt == CW'(CREDITS) && !cmd_vld_r)
          state_nxt = IDLE;
      end
      IDLE:    if (!quiesce_req) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= RUN;
      rr_ptr        <= '0;
      last_g        <= '0;
      burst_cnt     <= '0;
      credit_cnt    <= CW'(CREDITS);
      cmd_vld_r     <= 1'b0;
      cmd_r         <= '0;
      quiesce_ack_r <= 1'b0;
      credit_err_r  <= 1'b0;
    end else begin
      state         <= state_nxt;
      rr_ptr        <= rr_ptr_nxt;
      burst_cnt     <= burst_nxt;
      credit_cnt    <= credit_nxt;
      cmd_vld_r     <= grant;
      quiesce_ack_r <= (state_nxt == IDLE);
      credit_err_r  <= credit_err_r | credit_ovf;
      if (grant) begin
        last_g <= gnt_idx;
        cmd_r  <= req_cmd[gnt_idx*W +: W];
      end
    end
  end

endmodule

// File: tb/tb_ob_cmd_arb.sv
// Bench for ob_cmd_arb: directed scenarios plus random traffic, checked
// cycle by cycle against a behavioural arbitration/credit model.
module tb_ob_cmd_arb;
  localparam int N = 4, W = 32, CREDITS = 4, BURST = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_vld, req_en, req_accept;
  logic [N*W-1:0] req_cmd;
  logic           cmd_vld_r, cmd_full_r, cmd_credit, quiesce_req, quiesce_ack_r, credit_err_r;
  logic [W-1:0]   cmd_r;

  always #5 clk = ~clk;

  ob_cmd_arb #(.N(N), .W(W), .CREDITS(CREDITS), .BURST(BURST)) dut (
    .clk(clk), .rst(rst), .req_vld(req_vld), .req_cmd(req_cmd), .req_en(req_en),
    .req_accept(req_accept), .cmd_vld_r(cmd_vld_r), .cmd_r(cmd_r), .cmd_full_r(cmd_full_r),
    .cmd_credit(cmd_credit), .quiesce_req(quiesce_req), .quiesce_ack_r(quiesce_ack_r),
    .credit_err_r(credit_err_r)
  );

  int n_cmp = 0, n_bad = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Model: mode 0 = running, 1 = draining, 2 = idle
  int           m_mode, m_cnt, m_ptr, m_last, m_burst, outstanding;
  bit           m_vld, m_ack, m_err;
  logic [W-1:0] m_cmd;
  int           n_mode, n_cnt, n_ptr, n_last, n_burst;
  bit           n_vld, n_ack, n_err;
  logic [W-1:0] n_cmd;
  logic [N-1:0] exp_acc, obs_acc;

  function automatic void model_reset();
    m_mode = 0; m_cnt = CREDITS; m_ptr = 0; m_last = -1; m_burst = 0;
    m_vld = 0; m_ack = 0; m_err = 0; m_cmd = '0; outstanding = 0;
  endfunction

  function automatic void model_eval();
    logic [N-1:0] e;
    int g;
    e = req_vld & req_en;
    g = -1;
    if (m_mode == 0 && m_cnt > 0 && !cmd_full_r)
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (g < 0 && e[c]) g = c;
      end
    exp_acc = '0;
    n_ptr = m_ptr; n_last = m_last; n_burst = m_burst; n_cmd = m_cmd;
    n_vld = (g >= 0);
    if (g >= 0) begin
      exp_acc[g] = 1'b1;
      n_cmd   = req_cmd[g*W +: W];
      n_burst = (g == m_last) ? m_burst + 1 : 1;
      n_ptr   = (n_burst < BURST && (e & ~exp_acc) != '0) ? g : (g + 1) % N;
      n_last  = g;
    end
    n_err = m_err;
    n_cnt = m_cnt - (g >= 0 ? 1 : 0) + (cmd_credit ? 1 : 0);
    if (n_cnt > CREDITS) begin
      n_cnt = CREDITS;
      n_err = 1;
    end
    n_mode = m_mode;
    case (m_mode)
      0: if (quiesce_req) n_mode = 1;
      1: if (!quiesce_req) n_mode = 0; else if (m_cnt == CREDITS && !m_vld) n_mode = 2;
      default: if (!quiesce_req) n_mode = 0;
    endcase
    n_ack = (n_mode == 2);
  endfunction

  function automatic void model_commit();
    outstanding = outstanding + (n_vld ? 1 : 0) - (cmd_credit ? 1 : 0);
    if (outstanding < 0) outstanding = 0;
    m_mode = n_mode; m_cnt = n_cnt; m_ptr = n_ptr; m_last = n_last; m_burst = n_burst;
    m_vld = n_vld; m_cmd = n_cmd; m_ack = n_ack; m_err = n_err;
  endfunction

  function automatic int oh_idx(input logic [N-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  // Called with inputs already driven at posedge+1; returns at the next posedge+1.
  task automatic tick();
    @(negedge clk);
    model_eval();
    obs_acc = req_accept;
    check("accept", req_accept, exp_acc);
    @(posedge clk); #1;
    model_commit();
    check("cmd_vld_r", cmd_vld_r, m_vld);
    check("cmd_r", cmd_r, m_cmd);
    check("quiesce_ack_r", quiesce_ack_r, m_ack);
    check("credit_err_r", credit_err_r, m_err);
  endtask

  task automatic do_reset();
    #2 rst = 1'b0;
    #1;
    check("rst_cmd_vld_r", cmd_vld_r, 0);
    check("rst_cmd_r", cmd_r, 0);
    check("rst_ack", quiesce_ack_r, 0);
    check("rst_err", credit_err_r, 0);
    check("rst_accept", req_accept, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    model_reset();
  endtask

  task automatic idle_inputs();
    req_vld = '0; req_en = '1; cmd_full_r = 0; cmd_credit = 0; quiesce_req = 0;
  endtask

  logic [W-1:0] cmds [5];
  int fair_exp [9];
  int idx, n_acc, e_cycle, cnt;

  initial begin
    rst = 1'b0; req_cmd = '0;
    idle_inputs();
    model_reset();
    @(posedge clk); #1;
    do_reset();

    // Single requester: 4 credits then stall, one credit releases E
    cmds = '{32'hA000_0001, 32'hB000_0002, 32'hC000_0003, 32'hD000_0004, 32'hE000_0005};
    idx = 0; n_acc = 0; e_cycle = -1;
    for (int c = 0; c < 10; c++) begin
      req_vld = (idx < 5) ? 4'b0100 : 4'b0000;
      req_cmd[2*W +: W] = cmds[(idx < 5) ? idx : 4];
      cmd_credit = (c == 6);
      tick();
      if (obs_acc[2]) begin
        if (idx == 4) e_cycle = c;
        if (c <= 5) n_acc++;
        idx++;
      end
    end
    check("single_accepts", n_acc, 4);
    check("single_e_cycle", e_cycle, 7);

    // Fairness with burst limit
    idle_inputs(); do_reset();
    fair_exp = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
    req_vld = '1; cmd_credit = 1;
    for (int c = 0; c < 9; c++) begin
      for (int i = 0; i < N; i++) req_cmd[i*W +: W] = $urandom;
      tick();
      check($sformatf("fair_order%0d", c), oh_idx(obs_acc), fair_exp[c]);
    end

    // Enable mask, then full backstop
    idle_inputs(); do_reset();
    req_en = 4'b1010; req_vld = '1; cmd_credit = 1; cnt = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      check("mask_disabled", obs_acc & 4'b0101, 0);
      if (obs_acc != '0) cnt++;
    end
    check("mask_grants", cnt, 8);
    req_en = '1; cmd_credit = 0; cmd_full_r = 1;
    for (int c = 0; c < 4; c++) begin
      tick();
      check("full_no_accept", obs_acc, 0);
    end
    cmd_full_r = 0;

    // Issue and credit together at count 1
    idle_inputs(); do_reset();
    req_vld = 4'b0100;
    repeat (3) tick();
    cmd_credit = 1; tick();
    check("simul_grant", obs_acc, 4'b0100);
    cmd_credit = 0; tick();
    check("simul_next_grant", obs_acc, 4'b0100);
    tick();
    check("simul_exhausted", obs_acc, 0);

    // Quiesce with three outstanding
    idle_inputs(); do_reset();
    req_vld = '1;
    tick(); tick();
    quiesce_req = 1; tick();
    for (int c = 0; c < 2; c++) begin
      tick();
      check("quiesce_blocked", obs_acc, 0);
    end
    cmd_credit = 1;
    repeat (3) tick();
    check("ack_early", quiesce_ack_r, 0);
    cmd_credit = 0; tick();
    check("ack_rise", quiesce_ack_r, 1);
    quiesce_req = 0; tick();
    check("ack_clear", quiesce_ack_r, 0);
    tick();
    check("resume_ptr", oh_idx(obs_acc), 1);

    // Credit overflow, then async reset mid-burst
    idle_inputs(); do_reset();
    cmd_credit = 1; tick();
    check("err_set", credit_err_r, 1);
    cmd_credit = 0; req_vld = 4'b0100; cnt = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (obs_acc != '0) cnt++;
    end
    check("err_count_held", cnt, 4);
    idle_inputs(); do_reset();
    req_vld = '1; cmd_credit = 1;
    repeat (3) tick();
    check("burst_inflight", cmd_vld_r, 1);
    do_reset();
    idle_inputs();

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      req_vld    = N'($urandom);
      req_en     = ($urandom_range(0, 7) == 0) ? N'($urandom) : '1;
      for (int i = 0; i < N; i++) req_cmd[i*W +: W] = $urandom;
      cmd_full_r = ($urandom_range(0, 7) == 0);
      cmd_credit = (outstanding > 0) && ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 39) == 0) quiesce_req = ~quiesce_req;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
